// File: rtl/cam_entry_writer_pkg.sv
// Shared constants for the CAM entry writer: command opcodes, response
// status codes and the control FSM state encoding.
package cam_pkg;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_UPDATED   = 2'd1;
  localparam logic [1:0] ST_FULL      = 2'd2;
  localparam logic [1:0] ST_NOT_FOUND = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/cam_entry_writer_if.sv
// Command/response channel of the CAM entry writer. The master issues
// insert/delete commands; the slave (the writer) returns one status strobe each.
interface cam_entry_writer_if #(
  parameter int KEY_W = 4,
  parameter int VAL_W = 4,
  parameter int IDX_W = 3
) ();

  logic             cmd_vld;
  logic             cmd_rdy;
  logic             cmd_op;
  logic [KEY_W-1:0] cmd_key;
  logic [VAL_W-1:0] cmd_val;
  logic             rsp_vld;
  logic [1:0]       rsp_status;
  logic [IDX_W-1:0] rsp_idx;

  modport master (
    output cmd_vld, cmd_op, cmd_key, cmd_val,
    input  cmd_rdy, rsp_vld, rsp_status, rsp_idx
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_key, cmd_val,
    output cmd_rdy, rsp_vld, rsp_status, rsp_idx
  );

endinterface

// File: rtl/cam_entry_writer.sv
// Control-plane writer for the CAM entry table: scans all entries for a key hit
// and the lowest free slot, commits one insert/delete, and returns a status.
module cam_entry_writer
  import cam_pkg::*;
#(
  parameter int KEY_W = 4,
  parameter int VAL_W = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  cam_entry_writer_if.slave      cmd_if,
  output logic [DEPTH-1:0]       tbl_valid,
  output logic [DEPTH*KEY_W-1:0] tbl_key,
  output logic [DEPTH*VAL_W-1:0] tbl_val,
  output logic                   tbl_busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [KEY_W-1:0] key_reg [DEPTH];
  logic [VAL_W-1:0] val_reg [DEPTH];

  logic             op_reg;
  logic [KEY_W-1:0] lkey_reg;
  logic [VAL_W-1:0] lval_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic             hit_reg;
  logic [IDX_W-1:0] hit_idx_reg;
  logic             free_reg;
  logic [IDX_W-1:0] free_idx_reg;

  logic             rdy_reg;
  logic             rsp_vld_reg;
  logic [1:0]       status_reg;
  logic [IDX_W-1:0] rsp_idx_reg;
  logic             busy_reg;

  logic scan_hit;
  logic scan_free;

  assign scan_hit  = valid_reg[ptr_reg] && (key_reg[ptr_reg] == lkey_reg);
  assign scan_free = !valid_reg[ptr_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      valid_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        key_reg[i] <= '0;
        val_reg[i] <= '0;
      end
      op_reg       <= OP_INSERT;
      lkey_reg     <= '0;
      lval_reg     <= '0;
      ptr_reg      <= '0;
      hit_reg      <= 1'b0;
      hit_idx_reg  <= '0;
      free_reg     <= 1'b0;
      free_idx_reg <= '0;
      rdy_reg      <= 1'b1;
      rsp_vld_reg  <= 1'b0;
      status_reg   <= ST_OK;
      rsp_idx_reg  <= '0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          rsp_vld_reg <= 1'b0;
          if (cmd_if.cmd_vld && rdy_reg) begin
            op_reg    <= cmd_if.cmd_op;
            lkey_reg  <= cmd_if.cmd_key;
            lval_reg  <= cmd_if.cmd_val;
            ptr_reg   <= '0;
            hit_reg   <= 1'b0;
            free_reg  <= 1'b0;
            rdy_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= SCAN;
          end
        end

        // Full sweep every time, first match wins for both searches.
        SCAN: begin
          if (!hit_reg && scan_hit) begin
            hit_reg     <= 1'b1;
            hit_idx_reg <= ptr_reg;
          end
          if (!free_reg && scan_free) begin
            free_reg     <= 1'b1;
            free_idx_reg <= ptr_reg;
          end
          ptr_reg <= ptr_reg + 1'b1;
          if (ptr_reg == LAST_IDX) begin
            state_reg <= COMMIT;
          end
        end

        // Hit takes priority over free so a key is never duplicated.
        COMMIT: begin
          rsp_vld_reg <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= RESP;
          if (op_reg == OP_INSERT) begin
            if (hit_reg) begin
              val_reg[hit_idx_reg] <= lval_reg;
              status_reg           <= ST_UPDATED;
              rsp_idx_reg          <= hit_idx_reg;
            end else if (free_reg) begin
              valid_reg[free_idx_reg] <= 1'b1;
              key_reg[free_idx_reg]   <= lkey_reg;
              val_reg[free_idx_reg]   <= lval_reg;
              status_reg              <= ST_OK;
              rsp_idx_reg             <= free_idx_reg;
            end else begin
              status_reg  <= ST_FULL;
              rsp_idx_reg <= '0;
            end
          end else begin
            if (hit_reg) begin
              valid_reg[hit_idx_reg] <= 1'b0;
              status_reg             <= ST_OK;
              rsp_idx_reg            <= hit_idx_reg;
            end else begin
              status_reg  <= ST_NOT_FOUND;
              rsp_idx_reg <= '0;
            end
          end
        end

        RESP: begin
          rsp_vld_reg <= 1'b0;
          rdy_reg     <= 1'b1;
          state_reg   <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cmd_if.cmd_rdy    = rdy_reg;
  assign cmd_if.rsp_vld    = rsp_vld_reg;
  assign cmd_if.rsp_status = status_reg;
  assign cmd_if.rsp_idx    = rsp_idx_reg;
  assign tbl_busy          = busy_reg;
  assign tbl_valid         = valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign tbl_key[gi*KEY_W +: KEY_W] = key_reg[gi];
      assign tbl_val[gi*VAL_W +: VAL_W] = val_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_cam_entry_writer.sv
// Directed bench for cam_entry_writer: scoreboarded responses, table shadow
// comparison, latency/handshake checks and reset-during-scan behaviour.
module tb_cam_entry_writer;

  localparam int KEY_W = 4;
  localparam int VAL_W = 4;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [1:0]       status;
    logic [IDX_W-1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DEPTH-1:0]       tbl_valid;
  logic [DEPTH*KEY_W-1:0] tbl_key;
  logic [DEPTH*VAL_W-1:0] tbl_val;
  logic                   tbl_busy;

  cam_entry_writer_if #(.KEY_W(KEY_W), .VAL_W(VAL_W), .IDX_W(IDX_W)) cif ();

  cam_entry_writer #(.KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .cmd_if    (cif),
    .tbl_valid (tbl_valid),
    .tbl_key   (tbl_key),
    .tbl_val   (tbl_val),
    .tbl_busy  (tbl_busy)
  );

  always #5 clk = ~clk;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];

  logic             m_valid [DEPTH];
  logic [KEY_W-1:0] m_key   [DEPTH];
  logic [VAL_W-1:0] m_val   [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_key[i]   = '0;
      m_val[i]   = '0;
    end
  endtask

  // Shadow table updated with the command's intended effect.
  task automatic model_apply(input logic op, input logic [KEY_W-1:0] key, input logic [VAL_W-1:0] val);
    int hit;
    int free;
    hit = -1;
    free = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit < 0 && m_valid[i] && m_key[i] == key) hit = i;
      if (free < 0 && !m_valid[i]) free = i;
    end
    if (op == 1'b0) begin
      if (hit >= 0) m_val[hit] = val;
      else if (free >= 0) begin
        m_valid[free] = 1'b1;
        m_key[free]   = key;
        m_val[free]   = val;
      end
    end else if (hit >= 0) begin
      m_valid[hit] = 1'b0;
    end
  endtask

  task automatic check_table(input string tag);
    logic [DEPTH-1:0]       ev;
    logic [DEPTH*KEY_W-1:0] ek;
    logic [DEPTH*VAL_W-1:0] ew;
    for (int i = 0; i < DEPTH; i++) begin
      ev[i]               = m_valid[i];
      ek[i*KEY_W +: KEY_W] = m_key[i];
      ew[i*VAL_W +: VAL_W] = m_val[i];
    end
    chk({tag, "_valid"}, 32'(tbl_valid), 32'(ev));
    chk({tag, "_key"},   32'(tbl_key),   32'(ek));
    chk({tag, "_val"},   32'(tbl_val),   32'(ew));
  endtask

  task automatic do_cmd(input string tag, input logic op, input logic [KEY_W-1:0] key,
                        input logic [VAL_W-1:0] val, input logic [1:0] est,
                        input logic [IDX_W-1:0] eidx, input bit hold);
    exp_t e;
    int   n;
    int   cyc;
    bit   got;
    bit   rdy_ok;
    bit   busy_ok;
    e.status = est;
    e.idx    = eidx;
    sb.push_back(e);
    model_apply(op, key, val);
    cif.cmd_vld = 1'b1;
    cif.cmd_op  = op;
    cif.cmd_key = key;
    cif.cmd_val = val;
    n = 0;
    while (cif.cmd_rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept_wait"}, 32'(n < 40), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) cif.cmd_vld = 1'b0;
    cif.cmd_op  = ~op;
    cif.cmd_key = ~key;
    cif.cmd_val = ~val;
    cyc = 0;
    got = 1'b0;
    rdy_ok = 1'b1;
    busy_ok = 1'b1;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cif.rsp_vld === 1'b1) got = 1'b1;
      else begin
        if (cif.cmd_rdy !== 1'b0) rdy_ok = 1'b0;
        if (tbl_busy !== 1'b1) busy_ok = 1'b0;
      end
    end
    chk({tag, "_latency"},   32'(cyc), 32'd10);
    chk({tag, "_scan_rdy"},  32'(rdy_ok), 32'd1);
    chk({tag, "_scan_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_resp_rdy"},  32'(cif.cmd_rdy), 32'd0);
    chk({tag, "_resp_busy"}, 32'(tbl_busy), 32'd0);
    chk({tag, "_sb_pending"}, 32'(sb.size() != 0), 32'd1);
    if (got && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_status"}, 32'(cif.rsp_status), 32'(e.status));
      chk({tag, "_idx"},    32'(cif.rsp_idx),    32'(e.idx));
    end
    check_table(tag);
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, 32'(cif.rsp_vld), 32'd0);
    chk({tag, "_idle_rdy"},  32'(cif.cmd_rdy), 32'd1);
    $display("cmd %s op=%0d key=%0d val=%0d -> status=%0d idx=%0d latency=%0d",
             tag, op, key, val, est, eidx, cyc);
  endtask

  initial begin
    int  seen;
    cif.cmd_vld = 1'b0;
    cif.cmd_op  = 1'b0;
    cif.cmd_key = '0;
    cif.cmd_val = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_rdy",    32'(cif.cmd_rdy), 32'd1);
    chk("rst_rsp",    32'(cif.rsp_vld), 32'd0);
    chk("rst_status", 32'(cif.rsp_status), 32'd0);
    chk("rst_idx",    32'(cif.rsp_idx), 32'd0);
    chk("rst_busy",   32'(tbl_busy), 32'd0);
    check_table("rst");
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd("ins1", 1'b0, 4'd1, 4'd5, 2'd0, 3'd0, 1'b0);
    chk("ins1_valid_const", 32'(tbl_valid), 32'h01);
    chk("ins1_val_const",   32'(tbl_val[3:0]), 32'd5);

    do_cmd("upd1", 1'b0, 4'd1, 4'd7, 2'd1, 3'd0, 1'b0);
    chk("upd1_valid_const", 32'(tbl_valid), 32'h01);
    chk("upd1_val_const",   32'(tbl_val[3:0]), 32'd7);

    for (int k = 2; k <= 8; k++) begin
      do_cmd("fill", 1'b0, 4'(k), 4'(k + 3), 2'd0, 3'(k - 1), 1'b0);
    end
    do_cmd("full", 1'b0, 4'd9, 4'd4, 2'd2, 3'd0, 1'b0);
    chk("full_valid_const", 32'(tbl_valid), 32'hFF);

    do_cmd("del3", 1'b1, 4'd3, 4'd0, 2'd0, 3'd2, 1'b0);
    chk("del3_valid_const", 32'(tbl_valid), 32'hFB);
    do_cmd("reuse", 1'b0, 4'd9, 4'd4, 2'd0, 3'd2, 1'b0);
    chk("reuse_valid_const", 32'(tbl_valid), 32'hFF);

    do_cmd("del_absent", 1'b1, 4'd15, 4'd0, 2'd3, 3'd0, 1'b0);

    // cmd_vld held high across back-to-back commands
    do_cmd("hold_del4", 1'b1, 4'd4, 4'd0, 2'd0, 3'd3, 1'b1);
    do_cmd("hold_del5", 1'b1, 4'd5, 4'd0, 2'd0, 3'd4, 1'b1);
    do_cmd("hold_ins4", 1'b0, 4'd4, 4'd9, 2'd0, 3'd3, 1'b0);
    chk("hold_valid_const", 32'(tbl_valid), 32'hEF);

    // Reset in the middle of a scan
    cif.cmd_vld = 1'b1;
    cif.cmd_op  = 1'b0;
    cif.cmd_key = 4'd11;
    cif.cmd_val = 4'd3;
    @(posedge clk);
    #1;
    cif.cmd_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("midscan_busy", 32'(tbl_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("arst_rdy",  32'(cif.cmd_rdy), 32'd1);
    chk("arst_busy", 32'(tbl_busy), 32'd0);
    chk("arst_rsp",  32'(cif.rsp_vld), 32'd0);
    check_table("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cif.rsp_vld === 1'b1) seen++;
    end
    chk("arst_no_rsp", 32'(seen), 32'd0);
    chk("arst_sb_empty", 32'(sb.size()), 32'd0);
    $display("reset mid-scan: responses after reset=%0d", seen);

    do_cmd("post_rst", 1'b0, 4'd6, 4'd2, 2'd0, 3'd0, 1'b0);
    chk("post_rst_valid_const", 32'(tbl_valid), 32'h01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cam_entry_writer.md
Name: cam_entry_writer

Overview:
Control-plane writer that programs the entry table read by the cam/tcam lookup blocks. Accepts insert and delete commands over a valid/ready handshake. Scans the table one entry per cycle to find a key hit and the first free slot, commits the update, and returns a one-cycle status response. Drives the flattened table (valid/key/value) that the lookup side matches against, plus a busy flag while a scan is in progress.

Parameters:
KEY_W, 4, key width (matches lookup data_in width)
VAL_W, 4, value width (matches cam_out width)
DEPTH, 8, number of table entries, power of two, >= 2
IDX_W, $clog2(DEPTH), entry index width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; all state cleared while low
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready; high only in IDLE
cmd_op  in  1  0 = insert/update, 1 = delete
cmd_key  in  KEY_W  command key
cmd_val  in  VAL_W  value for insert; ignored on delete
rsp_vld  out  1  one-cycle response strobe
rsp_status  out  2  0 OK_NEW/DELETED, 1 UPDATED, 2 FULL, 3 NOT_FOUND
rsp_idx  out  IDX_W  entry index affected; 0 for FULL/NOT_FOUND
tbl_valid  out  DEPTH  per-entry valid bits
tbl_key  out  DEPTH*KEY_W  entry i key at bits [i*KEY_W +: KEY_W]
tbl_val  out  DEPTH*VAL_W  entry i value at bits [i*VAL_W +: VAL_W]
tbl_busy  out  1  high in SCAN and COMMIT; lookups may see pre-update table

Behaviour:
- Reset (reset low): state IDLE; cmd_rdy=1, rsp_vld=0, rsp_status=0, rsp_idx=0, tbl_valid/tbl_key/tbl_val all 0, tbl_busy=0.
- FSM states and transitions:
  - IDLE: cmd_rdy=1. On cmd_vld&cmd_rdy, latch op/key/val, clear the hit and free flags, set scan pointer 0, go to SCAN.
  - SCAN: one entry per cycle, pointer 0..DEPTH-1, lowest index first.
    - Record the first index with valid & key==latched key (hit).
    - Record the first index with valid==0 (free).
    - After entry DEPTH-1, go to COMMIT. The pointer wraps to 0; no early exit.
  - COMMIT: apply the update on the exiting edge, go to RESP.
    - Insert with hit: write value at the hit index. Status UPDATED.
    - Insert, no hit, free found: set valid, write key and value at the free index. Status OK_NEW.
    - Insert, no hit, no free slot: table unchanged. Status FULL.
    - Delete with hit: clear valid at the hit index; key/value bits retained. Status OK.
    - Delete, no hit: table unchanged. Status NOT_FOUND.
  - RESP: rsp_vld=1 for exactly one cycle with status and index. The table update is already visible. Return to IDLE.
- Latency:
  - Accept edge at cycle T; rsp_vld high in cycle T+DEPTH+2.
  - Next command accepted at earliest in the cycle after RESP, so throughput is one command per DEPTH+3 cycles.
- Responses have no backpressure.
- cmd_* inputs are don't-care outside IDLE. Key/value are latched at accept, so later input changes have no effect.
- The hit check precedes the free check: no duplicate keys are ever created.
- Deleted entries are reusable; an insert takes the lowest free index.
- Reset mid-SCAN or mid-COMMIT: the command is discarded, no response is issued, and the table clears.
- tbl_busy is the only indication to the lookup path. The table changes only on the COMMIT exit edge, in a single cycle.

Decomposition:
- Package cam_pkg holds:
  - OP_INSERT/OP_DELETE constants.
  - 2-bit status constants ST_OK, ST_UPDATED, ST_FULL, ST_NOT_FOUND.
  - State encoding IDLE/SCAN/COMMIT/RESP.
- Single module. Entry storage is a register array inside it; no sub-module is needed.

Test Plan (DEPTH=8, KEY_W=VAL_W=4):
- Release reset, insert key 1 val 5 -> rsp_vld exactly 10 cycles after the accept edge; status 0, idx 0, tbl_valid=8'h01, tbl_val[3:0]=5.
- Insert key 1 val 7 -> status 1 (UPDATED), idx 0, tbl_val[3:0]=7, tbl_valid unchanged.
- Insert keys 2..8 to fill the table (idx 1..7), then insert key 9 -> status 2 (FULL), idx 0, tbl_valid=8'hFF, table unchanged.
- Delete key 3 -> status 0, idx 2, tbl_valid=8'hFB; insert key 9 val 4 -> status 0, idx 2, tbl_valid=8'hFF.
- Delete absent key 15 -> status 3 (NOT_FOUND), idx 0.
- Hold cmd_vld high continuously -> cmd_rdy=0 throughout SCAN/COMMIT/RESP, one response per command.
- Assert reset low during SCAN -> no rsp_vld, all tbl_* zero, cmd_rdy=1, tbl_busy=0 immediately.
